cons_run_ctrl: RTL and testbench

Console run/halt sequencer for the KS10 CPU. It sits between the console host interface and the CPU console inputs (consRUN, consCONT, consEXEC, consSTEP, consTIMEREN, consTRAPEN, consCACHEEN). It turns one-shot host commands into correctly ordered level and handshake sequences against the CPU status outputs (cpuRUN, cpuCONT, cpuHALT), and it holds the console configuration enables.

---
 rtl/ks10_cons_pkg.sv | 24 ++
 rtl/cons_timeout.sv | 28 ++
 rtl/cons_run_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_cons_run_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ks10_cons_pkg.sv
// KS10 console run/halt sequencer: shared command codes, FSM states
// and configuration reset values.
package ks10_cons_pkg;

   localparam logic [2:0] CMD_NOP  = 3'd0;
   localparam logic [2:0] CMD_RUN  = 3'd1;
   localparam logic [2:0] CMD_HALT = 3'd2;
   localparam logic [2:0] CMD_STEP = 3'd3;
   localparam logic [2:0] CMD_CONT = 3'd4;
   localparam logic [2:0] CMD_EXEC = 3'd5;

   typedef enum logic [2:0] {
      IDLE,
      STROBE,
      WAIT_RUN,
      WAIT_HALT,
      FINISH
   } state_t;

   localparam logic RST_TIMEREN = 1'b1;
   localparam logic RST_TRAPEN  = 1'b1;
   localparam logic RST_CACHEEN = 1'b0;

endpackage

// File: rtl/cons_timeout.sv
// Acknowledge-wait watchdog: counts cycles while enabled and flags the
// cycle whose increment would reach TIMEOUT.
module cons_timeout #(
   parameter int TIMEOUT = 65535,
   parameter int TOW     = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TOW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == TOW'(TIMEOUT - 1));

endmodule

// File: rtl/cons_run_ctrl.sv
// KS10 console run/halt sequencer: turns host commands into ordered
// console control/handshake sequences and holds the console enables.
module cons_run_ctrl
   import ks10_cons_pkg::*;
#(
   parameter int TIMEOUT = 65535,
   parameter int TOW     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_code,
   output logic       cmd_ready,
   input  logic       cfg_wr,
   input  logic [2:0] cfg_data,
   input  logic       cpuRUN,
   input  logic       cpuCONT,
   input  logic       cpuHALT,
   output logic       consRUN,
   output logic       consCONT,
   output logic       consEXEC,
   output logic       consSTEP,
   output logic       consTIMEREN,
   output logic       consTRAPEN,
   output logic       consCACHEEN,
   output logic       done,
   output logic       err_timeout,
   output logic       err_illegal,
   output logic       halt_event
);

   state_t state, nextState;

   logic retRun, retRunNext;
   logic runNext, contNext, stepNext, execNext;
   logic doneNext, errTNext, errINext, readyNext;
   logic haltQ;
   logic accept, waiting, cntClr, expired;
   logic unusedRun;

   // cpuRUN is status only; sequencing keys off cpuHALT
   assign unusedRun = cpuRUN;

   assign accept  = cmd_valid && cmd_ready;
   assign waiting = (state == STROBE) || (state == WAIT_RUN) ||
                    (state == WAIT_HALT);
   assign cntClr  = (nextState != state);

   cons_timeout #(
      .TIMEOUT (TIMEOUT),
      .TOW     (TOW)
   ) uTimeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (cntClr),
      .en      (waiting),
      .expired (expired)
   );

   always_comb begin
      nextState  = state;
      retRunNext = retRun;
      runNext    = consRUN;
      contNext   = consCONT;
      stepNext   = consSTEP;
      execNext   = consEXEC;
      doneNext   = 1'b0;
      errTNext   = err_timeout;
      errINext   = err_illegal;
      readyNext  = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               errTNext = 1'b0;
               errINext = 1'b0;
               case (cmd_code)
                  CMD_NOP: nextState = FINISH;
                  CMD_RUN: begin
                     runNext = 1'b1;
                     if (cpuHALT) begin
                        nextState  = STROBE;
                        contNext   = 1'b1;
                        retRunNext = 1'b1;
                     end else begin
                        nextState = FINISH;
                     end
                  end
                  CMD_HALT: begin
                     runNext   = 1'b0;
                     nextState = WAIT_HALT;
                  end
                  CMD_STEP: begin
                     nextState  = STROBE;
                     contNext   = 1'b1;
                     stepNext   = 1'b1;
                     retRunNext = 1'b0;
                  end
                  CMD_CONT: begin
                     nextState  = STROBE;
                     contNext   = 1'b1;
                     retRunNext = 1'b1;
                  end
                  CMD_EXEC: begin
                     nextState  = STROBE;
                     contNext   = 1'b1;
                     execNext   = 1'b1;
                     retRunNext = 1'b0;
                  end
                  default: errINext = 1'b1;
               endcase
            end
         end
         STROBE: begin
            // acknowledge wins over a coincident timeout
            if (cpuCONT) begin
               contNext  = 1'b0;
               stepNext  = 1'b0;
               execNext  = 1'b0;
               nextState = retRun ? WAIT_RUN : WAIT_HALT;
            end else if (expired) begin
               contNext  = 1'b0;
               stepNext  = 1'b0;
               execNext  = 1'b0;
               errTNext  = 1'b1;
               nextState = IDLE;
            end
         end
         WAIT_RUN: begin
            if (!cpuHALT) begin
               nextState = FINISH;
            end else if (expired) begin
               errTNext  = 1'b1;
               nextState = IDLE;
            end
         end
         WAIT_HALT: begin
            if (cpuHALT) begin
               nextState = FINISH;
            end else if (expired) begin
               errTNext  = 1'b1;
               nextState = IDLE;
            end
         end
         FINISH: begin
            doneNext  = 1'b1;
            nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
      // ready is held off for the done cycle after FINISH
      readyNext = (nextState == IDLE) && (state != FINISH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         retRun      <= 1'b0;
         cmd_ready   <= 1'b1;
         consRUN     <= 1'b0;
         consCONT    <= 1'b0;
         consSTEP    <= 1'b0;
         consEXEC    <= 1'b0;
         done        <= 1'b0;
         err_timeout <= 1'b0;
         err_illegal <= 1'b0;
         consTIMEREN <= RST_TIMEREN;
         consTRAPEN  <= RST_TRAPEN;
         consCACHEEN <= RST_CACHEEN;
         haltQ       <= 1'b0;
         halt_event  <= 1'b0;
      end else begin
         state       <= nextState;
         retRun      <= retRunNext;
         cmd_ready   <= readyNext;
         consRUN     <= runNext;
         consCONT    <= contNext;
         consSTEP    <= stepNext;
         consEXEC    <= execNext;
         done        <= doneNext;
         err_timeout <= errTNext;
         err_illegal <= errINext;
         if (cfg_wr) begin
            consCACHEEN <= cfg_data[2];
            consTRAPEN  <= cfg_data[1];
            consTIMEREN <= cfg_data[0];
         end
         haltQ      <= cpuHALT;
         halt_event <= cpuHALT & ~haltQ;
      end
   end

endmodule

// File: tb/tb_cons_run_ctrl.sv
// Directed vector bench for cons_run_ctrl with a short timeout so the
// watchdog paths are reachable in a few cycles.
module tb_cons_run_ctrl;

   localparam int TO = 8;

   logic       clk;
   logic       rst;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic       cmd_ready;
   logic       cfg_wr;
   logic [2:0] cfg_data;
   logic       cpuRUN;
   logic       cpuCONT;
   logic       cpuHALT;
   logic       consRUN;
   logic       consCONT;
   logic       consEXEC;
   logic       consSTEP;
   logic       consTIMEREN;
   logic       consTRAPEN;
   logic       consCACHEEN;
   logic       done;
   logic       err_timeout;
   logic       err_illegal;
   logic       halt_event;

   // {ready,run,cont,step,exec}_{cache,trap,timer}_{done,errT,errI,hev}
   logic [11:0] obs;
   assign obs = {cmd_ready, consRUN, consCONT, consSTEP, consEXEC,
                 consCACHEEN, consTRAPEN, consTIMEREN,
                 done, err_timeout, err_illegal, halt_event};

   assign cpuRUN = ~cpuHALT;

   cons_run_ctrl #(
      .TIMEOUT (TO),
      .TOW     (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_code    (cmd_code),
      .cmd_ready   (cmd_ready),
      .cfg_wr      (cfg_wr),
      .cfg_data    (cfg_data),
      .cpuRUN      (cpuRUN),
      .cpuCONT     (cpuCONT),
      .cpuHALT     (cpuHALT),
      .consRUN     (consRUN),
      .consCONT    (consCONT),
      .consEXEC    (consEXEC),
      .consSTEP    (consSTEP),
      .consTIMEREN (consTIMEREN),
      .consTRAPEN  (consTRAPEN),
      .consCACHEEN (consCACHEEN),
      .done        (done),
      .err_timeout (err_timeout),
      .err_illegal (err_illegal),
      .halt_event  (halt_event)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [2:0]  code;
      logic        cfgWr;
      logic [2:0]  cfgData;
      logic        cont;
      logic        halt;
      logic [11:0] exp;
   } vec_t;

   vec_t tbl[$];
   int   nVec = 0;
   int   nBad = 0;

   task automatic add(input logic v, input logic [2:0] c,
                      input logic w, input logic [2:0] d,
                      input logic ct, input logic h,
                      input logic [11:0] e);
      vec_t r;
      r.valid = v; r.code = c; r.cfgWr = w; r.cfgData = d;
      r.cont = ct; r.halt = h; r.exp = e;
      tbl.push_back(r);
   endtask

   task automatic check(input string nm, input logic [11:0] got,
                        input logic [11:0] exp);
      nVec++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s got=%b exp=%b", nm, got, exp);
      end
   endtask

   initial begin
      int n;
      // v  code  wr data ct h  expected
      // RUN from halt: CONT ack on 3rd strobe cycle, HALT falls 3 later
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0001);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0000);
      add(1, 3'd1, 0, 3'd0, 0, 1, 12'b01100_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b01100_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b01100_011_0000);
      add(0, 3'd0, 0, 3'd0, 1, 1, 12'b01000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b01000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b01000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b01000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b01000_011_1000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b11000_011_0000);
      // HALT while running, cpuHALT rises 5 cycles after accept
      add(1, 3'd2, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_0001);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_1000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0000);
      // STEP: two strobe cycles, then CPU runs and re-halts
      add(1, 3'd3, 0, 3'd0, 0, 1, 12'b00110_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00110_011_0000);
      add(0, 3'd0, 0, 3'd0, 1, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_0001);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_1000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0000);
      // EXEC with no CONT ack: 8 strobe cycles, then timeout
      add(1, 3'd5, 0, 3'd0, 0, 1, 12'b00101_011_0000);
      for (int i = 0; i < 7; i++)
         add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00101_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0100);
      add(1, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_1000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0000);
      // illegal code, then NOP clears it
      add(1, 3'd7, 0, 3'd0, 0, 1, 12'b10000_011_0010);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0010);
      add(1, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_0000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b00000_011_1000);
      add(0, 3'd0, 0, 3'd0, 0, 1, 12'b10000_011_0000);
      // CONT with cfg write in the same cycle; ack on first cycle
      add(1, 3'd4, 1, 3'b110, 0, 1, 12'b00100_110_0000);
      add(0, 3'd0, 0, 3'd0, 1, 0, 12'b00000_110_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_110_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b00000_110_1000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b10000_110_0000);
      // RUN while the CPU is already running: straight to FINISH
      add(1, 3'd1, 0, 3'd0, 0, 0, 12'b01000_110_0000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b01000_110_1000);
      add(0, 3'd0, 0, 3'd0, 0, 0, 12'b11000_110_0000);

      rst = 1'b1;
      cmd_valid = 1'b0; cmd_code = 3'd0;
      cfg_wr = 1'b0; cfg_data = 3'd0;
      cpuCONT = 1'b0; cpuHALT = 1'b1;
      #3;
      check("reset", obs, 12'b10000_011_0000);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         cmd_valid = tbl[i].valid;
         cmd_code  = tbl[i].code;
         cfg_wr    = tbl[i].cfgWr;
         cfg_data  = tbl[i].cfgData;
         cpuCONT   = tbl[i].cont;
         cpuHALT   = tbl[i].halt;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), obs, tbl[i].exp);
      end
      cmd_valid = 1'b0; cfg_wr = 1'b0; cpuCONT = 1'b0;

      // HALT that never sees cpuHALT: watchdog in WAIT_HALT
      cpuHALT = 1'b0;
      cmd_valid = 1'b1; cmd_code = 3'd2;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      n = 0;
      while (n < 20 && !err_timeout) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("halt_to_cycles", 12'(n), 12'(TO));
      check("halt_to_state", obs, 12'b10000_110_0100);

      // async reset while in WAIT_RUN, then cfg write
      cpuHALT = 1'b1;
      cmd_valid = 1'b1; cmd_code = 3'd1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      check("run_strobe", obs, 12'b01100_110_0001);
      cpuCONT = 1'b1;
      @(posedge clk);
      #1;
      cpuCONT = 1'b0;
      check("run_waitrun", obs, 12'b01000_110_0000);
      #2 rst = 1'b1;
      #1;
      check("async_reset", obs, 12'b10000_011_0000);
      cpuHALT = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cfg_wr = 1'b1; cfg_data = 3'b101;
      @(posedge clk);
      #1;
      cfg_wr = 1'b0;
      check("cfg_after_reset", obs, 12'b10000_101_0000);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
      $finish;
   end

endmodule
